divconv: RTL and testbench
==========================

DIVCONV -- requirements
Module: divconv

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/register width in bits.
REQ-002 SHALL have parameter FRAC, default 6, fraction bits; values are unsigned fixed point with WIDTH-FRAC integer bits (Q2.6 at defaults).
REQ-003 SHALL have port Clk  input  1  single clock, all registers update on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Q  output  WIDTH  quotient estimate, equal to regc_out.
REQ-006 SHALL have port rega_out  output  WIDTH  register A, the divisor iterate D_i.
REQ-007 SHALL have port regb_out  output  WIDTH  register B, the correction factor R_i.
REQ-008 SHALL have port regc_out  output  WIDTH  register C, the dividend/quotient iterate X_i.
REQ-009 SHALL have port D  input  WIDTH  divisor, expected range [1.0, 2.0).
REQ-010 SHALL have port X  input  WIDTH  dividend.
REQ-011 SHALL have port sel_muxa  input  2  mux A select: 00 rega, 01 X, 10 D, 11 constant 1.0.
REQ-012 SHALL have port sel_muxb  input  2  mux B select: 00 X, 01 D, 10 regb, 11 regc.
REQ-013 SHALL have ports load_rega, load_regb, load_regc  input  1 each  register load enables, active-high.

Function
REQ-014 SHALL compute the complement TWO - muxa_out, where TWO is 2.0 (0x80 at defaults), as a WIDTH-bit modulo difference; the value wraps when muxa_out > 2.0 and is not saturated.
REQ-015 SHALL compute mulA = (muxa_out * regb) and mulB = (muxb_out * regb) as full 2*WIDTH-bit products, then truncate each to bits [WIDTH+FRAC-1:FRAC] with no rounding and no saturation.
REQ-016 On a rising Clk edge with load_regb=1, regb SHALL take the complement value.
REQ-017 On a rising Clk edge with load_rega=1, rega SHALL take mulA.
REQ-018 On a rising Clk edge with load_regc=1, regc SHALL take mulB.
REQ-019 A register whose load is 0 SHALL hold its value.
REQ-020 Any combination of loads MAY be asserted in the same cycle; every register SHALL sample products and complements formed from pre-edge register values.
REQ-021 Outputs SHALL be driven directly from the registers, so each load is visible one cycle after it is sampled; Q SHALL equal regc_out.
REQ-022 The block SHALL contain no internal sequencer; the external controller runs the Goldschmidt steps below.
  - S1: muxa=10, load B gives R0 = 2 - D.
  - S2: muxa=10, muxb=00, load A and C gives D1 = D*R0, X1 = X*R0.
  - S3: muxa=00, load B gives R = 2 - rega.
  - S4: muxa=00, muxb=11, load A and C.
  - S3 and S4 then repeat.
REQ-023 The selects SHALL be don't-care in cycles where no dependent register loads.

Reset
REQ-024 Rst_n=0 SHALL clear rega, regb and regc to 0 immediately, independent of Clk; Q SHALL then be 0.
REQ-025 Reset asserted mid-sequence SHALL override any load; after release the registers SHALL hold 0 until loaded.

Structure
REQ-026 Constants SHALL reside in a shared package divconv_pkg: ONE (0x40), TWO (0x80), and the mux-select encodings for both muxes.
REQ-027 The multiply-and-truncate SHALL be one sub-module, divconv_mul, instantiated twice (mulA, mulB).
REQ-028 The registers SHALL be plain load-enabled flops in divconv.

Verification
REQ-029 SHALL verify reset: set all registers non-zero, pulse Rst_n low between clock edges -> rega=regb=regc=Q=0x00 immediately.
REQ-030 SHALL verify the D=X=0x50 (1.25) sequence S1,S2,S3,S4,S3,S4 -> regb=0x30; A=C=0x3C; regb=0x44; A=C=0x3F; regb=0x41; A=C=0x3F (Q near 1.0).
REQ-031 SHALL verify the D=0x60 (1.5), X=0x40 (1.0) sequence S1,S2,S3,S4,S3,S4 -> regb=0x20; A=0x30, C=0x20; regb=0x50; A=0x3C, C=0x28; regb=0x44; A=0x3F, C=0x2A (Q near 0.667).
REQ-032 SHALL verify hold: all loads 0 for 3 cycles while the selects and D/X toggle -> no register changes.
REQ-033 SHALL verify wrap: D=0xC0, S1 -> regb=0xC0 (modulo wrap, no saturation).
REQ-034 SHALL verify simultaneous loads: assert A, B and C in one cycle -> A and C use the old regb value, and B gets the complement of the old mux A value.

Source files
------------

// File: rtl/divconv_pkg.sv
// Shared constants for the Goldschmidt divider datapath.
//   ONE / TWO  : fixed-point 1.0 and 2.0 in the default Q2.6 format
//   muxa_sel_e : mux A select encodings (rega, X, D, 1.0)
//   muxb_sel_e : mux B select encodings (X, D, regb, regc)
package divconv_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 6;

  localparam logic [DEF_WIDTH-1:0] ONE = 8'h40;
  localparam logic [DEF_WIDTH-1:0] TWO = 8'h80;

  typedef enum logic [1:0] {
    MUXA_REGA = 2'b00,
    MUXA_X    = 2'b01,
    MUXA_D    = 2'b10,
    MUXA_ONE  = 2'b11
  } muxa_sel_e;

  typedef enum logic [1:0] {
    MUXB_X    = 2'b00,
    MUXB_D    = 2'b01,
    MUXB_REGB = 2'b10,
    MUXB_REGC = 2'b11
  } muxb_sel_e;

endpackage

// File: rtl/divconv_mul.sv
// Unsigned fixed-point multiply with truncation.
//   a, b : WIDTH-bit operands with FRAC fraction bits
//   p    : bits [WIDTH+FRAC-1:FRAC] of the full 2*WIDTH-bit product;
//          low bits are dropped (no rounding), high bits are dropped
//          (no saturation)
module divconv_mul #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] prod;

  assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign p    = WIDTH'(prod >> FRAC);

endmodule

// File: rtl/divconv.sv
// Goldschmidt division datapath: three load-enabled registers, two input
// muxes, a 2-x complement and two truncating multipliers. Sequencing is
// done by an external controller through the selects and load enables.
//   Clk, Rst_n       : clock, asynchronous active-low reset
//   D, X             : divisor (in [1.0,2.0)) and dividend
//   sel_muxa/muxb    : operand selects
//   load_rega/b/c    : register load enables
//   rega_out (D_i), regb_out (R_i), regc_out (X_i), Q (= regc_out)
module divconv
  import divconv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] X,
  input  logic [1:0]       sel_muxa,
  input  logic [1:0]       sel_muxb,
  input  logic             load_rega,
  input  logic             load_regb,
  input  logic             load_regc,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] rega_out,
  output logic [WIDTH-1:0] regb_out,
  output logic [WIDTH-1:0] regc_out
);

  // Rescale the package constants to this instance's fraction width.
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(ONE >> DEF_FRAC) << FRAC;
  localparam logic [WIDTH-1:0] TWO_C = WIDTH'(TWO >> DEF_FRAC) << FRAC;

  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [WIDTH-1:0] regc_q, regc_d;
  logic [WIDTH-1:0] muxa_out, muxb_out;
  logic [WIDTH-1:0] compl;
  logic [WIDTH-1:0] mula, mulb;

  always_comb begin
    muxa_out = rega_q;
    unique case (muxa_sel_e'(sel_muxa))
      MUXA_REGA: muxa_out = rega_q;
      MUXA_X:    muxa_out = X;
      MUXA_D:    muxa_out = D;
      MUXA_ONE:  muxa_out = ONE_C;
      default:   muxa_out = rega_q;
    endcase
  end

  always_comb begin
    muxb_out = X;
    unique case (muxb_sel_e'(sel_muxb))
      MUXB_X:    muxb_out = X;
      MUXB_D:    muxb_out = D;
      MUXB_REGB: muxb_out = regb_q;
      MUXB_REGC: muxb_out = regc_q;
      default:   muxb_out = X;
    endcase
  end

  // Modulo subtraction: an operand above 2.0 wraps rather than clamps.
  assign compl = TWO_C - muxa_out;

  divconv_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mula (
    .a (muxa_out),
    .b (regb_q),
    .p (mula)
  );

  divconv_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mulb (
    .a (muxb_out),
    .b (regb_q),
    .p (mulb)
  );

  // All next values come from pre-edge register state, so any mix of
  // loads in one cycle is safe.
  always_comb begin
    rega_d = rega_q;
    regb_d = regb_q;
    regc_d = regc_q;
    if (load_rega) rega_d = mula;
    if (load_regb) regb_d = compl;
    if (load_regc) regc_d = mulb;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rega_q <= '0;
      regb_q <= '0;
      regc_q <= '0;
    end else begin
      rega_q <= rega_d;
      regb_q <= regb_d;
      regc_q <= regc_d;
    end
  end

  assign rega_out = rega_q;
  assign regb_out = regb_q;
  assign regc_out = regc_q;
  assign Q        = regc_q;

endmodule

// File: tb/tb_divconv.sv
// Self-checking bench for divconv: expected register triples are queued
// as each controller step is driven and popped after the clock edge.
module tb_divconv;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [7:0] D = '0, X = '0;
  logic [1:0] sel_muxa = '0, sel_muxb = '0;
  logic       load_rega = 1'b0, load_regb = 1'b0, load_regc = 1'b0;
  logic [7:0] Q, rega_out, regb_out, regc_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];

  divconv dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .D         (D),
    .X         (X),
    .sel_muxa  (sel_muxa),
    .sel_muxb  (sel_muxb),
    .load_rega (load_rega),
    .load_regb (load_regb),
    .load_regc (load_regc),
    .Q         (Q),
    .rega_out  (rega_out),
    .regb_out  (regb_out),
    .regc_out  (regc_out)
  );

  always #5 Clk = ~Clk;

  // Drive one controller step on the falling edge, let it be sampled on
  // the rising edge, then drop the loads 1 time unit later.
  task automatic step(input logic [1:0] sa, input logic [1:0] sbs,
                      input logic la, input logic lb, input logic lc);
    @(negedge Clk);
    sel_muxa  = sa;
    sel_muxb  = sbs;
    load_rega = la;
    load_regb = lb;
    load_regc = lc;
    @(posedge Clk);
    #1;
    load_rega = 1'b0;
    load_regb = 1'b0;
    load_regc = 1'b0;
  endtask

  task automatic test_reset_state();
    Rst_n = 1'b0;
    #3;
    checks++;
    if ({rega_out, regb_out, regc_out, Q} !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got a=%h b=%h c=%h q=%h, want all 00",
               rega_out, regb_out, regc_out, Q);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // S1,S2,S3,S4,S3,S4 for one operand pair; expected triples are given.
  task automatic run_gs(input string tag, input logic [7:0] d, input logic [7:0] x,
                        input logic [7:0] ea[6], input logic [7:0] eb[6],
                        input logic [7:0] ec[6]);
    exp_t e;
    D = d;
    X = x;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{$sformatf("%s_step%0d", tag, i), ea[i], eb[i], ec[i]});
      case (i)
        0:       step(2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        1:       step(2'b10, 2'b00, 1'b1, 1'b0, 1'b1);
        2, 4:    step(2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
        default: step(2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
      endcase
      e = sb.pop_front();
      checks++;
      if (rega_out !== e.a || regb_out !== e.b || regc_out !== e.c || Q !== e.c) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h c=%h q=%h, want a=%h b=%h c=%h q=%h",
                 e.name, rega_out, regb_out, regc_out, Q, e.a, e.b, e.c, e.c);
      end
    end
  endtask

  task automatic test_seq_125();
    logic [7:0] ea[6] = '{8'h00, 8'h3C, 8'h3C, 8'h3F, 8'h3F, 8'h3F};
    logic [7:0] eb[6] = '{8'h30, 8'h30, 8'h44, 8'h44, 8'h41, 8'h41};
    logic [7:0] ec[6] = '{8'h00, 8'h3C, 8'h3C, 8'h3F, 8'h3F, 8'h3F};
    run_gs("seq_125", 8'h50, 8'h50, ea, eb, ec);
  endtask

  // Starts from the registers left by the previous sequence (A=C=0x3F).
  task automatic test_seq_1_over_15();
    logic [7:0] ea[6] = '{8'h3F, 8'h30, 8'h30, 8'h3C, 8'h3C, 8'h3F};
    logic [7:0] eb[6] = '{8'h20, 8'h20, 8'h50, 8'h50, 8'h44, 8'h44};
    logic [7:0] ec[6] = '{8'h3F, 8'h20, 8'h20, 8'h28, 8'h28, 8'h2A};
    run_gs("seq_1_over_15", 8'h60, 8'h40, ea, eb, ec);
  endtask

  task automatic test_hold();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("hold_%0d", i), 8'h3F, 8'h44, 8'h2A});
      D = 8'($urandom);
      X = 8'($urandom);
      step(2'(i + 1), 2'(3 - i), 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (rega_out !== e.a || regb_out !== e.b || regc_out !== e.c) begin
        errors++;
        $display("FAIL %s: got a=%h b=%h c=%h, want a=%h b=%h c=%h",
                 e.name, rega_out, regb_out, regc_out, e.a, e.b, e.c);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    D = 8'hC0;
    sb.push_back('{"wrap", 8'h3F, 8'hC0, 8'h2A});
    step(2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (rega_out !== e.a || regb_out !== e.b || regc_out !== e.c) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h c=%h, want a=%h b=%h c=%h",
               e.name, rega_out, regb_out, regc_out, e.a, e.b, e.c);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    // a=3F b=C0 c=2A: A=3F*C0>>6=BD, C=2A*C0>>6=7E, B=80-3F=41
    sb.push_back('{"simul_rega", 8'hBD, 8'h41, 8'h7E});
    step(2'b00, 2'b11, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (rega_out !== e.a || regb_out !== e.b || regc_out !== e.c) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h c=%h, want a=%h b=%h c=%h",
               e.name, rega_out, regb_out, regc_out, e.a, e.b, e.c);
    end
    // X=90 via both muxes, old b=41: A=C=90*41>>6=92, B=80-90 wraps to F0
    X = 8'h90;
    sb.push_back('{"simul_x", 8'h92, 8'hF0, 8'h92});
    step(2'b01, 2'b00, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (rega_out !== e.a || regb_out !== e.b || regc_out !== e.c) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h c=%h, want a=%h b=%h c=%h",
               e.name, rega_out, regb_out, regc_out, e.a, e.b, e.c);
    end
    // Constant 1.0 on mux A, regb on mux B, old b=F0:
    // A=40*F0>>6=F0, C=F0*F0>>6=(E100>>6)&FF=84, B=80-40=40
    sb.push_back('{"simul_one", 8'hF0, 8'h40, 8'h84});
    step(2'b11, 2'b10, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (rega_out !== e.a || regb_out !== e.b || regc_out !== e.c) begin
      errors++;
      $display("FAIL %s: got a=%h b=%h c=%h, want a=%h b=%h c=%h",
               e.name, rega_out, regb_out, regc_out, e.a, e.b, e.c);
    end
  endtask

  task automatic test_reset_mid();
    // Registers are non-zero here; assert reset between edges with loads up.
    @(posedge Clk);
    #2;
    D = 8'h50;
    sel_muxa  = 2'b10;
    load_rega = 1'b1;
    load_regb = 1'b1;
    load_regc = 1'b1;
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({rega_out, regb_out, regc_out, Q} !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: got a=%h b=%h c=%h q=%h, want all 00",
               rega_out, regb_out, regc_out, Q);
    end
    @(posedge Clk);
    #1;
    checks++;
    if ({rega_out, regb_out, regc_out} !== 24'h0) begin
      errors++;
      $display("FAIL reset_over_load: got a=%h b=%h c=%h, want all 00",
               rega_out, regb_out, regc_out);
    end
    @(negedge Clk);
    load_rega = 1'b0;
    load_regb = 1'b0;
    load_regc = 1'b0;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if ({rega_out, regb_out, regc_out, Q} !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_hold: got a=%h b=%h c=%h q=%h, want all 00",
               rega_out, regb_out, regc_out, Q);
    end
  endtask

  initial begin
    test_reset_state();
    test_seq_125();
    test_seq_1_over_15();
    test_hold();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
